fip_vector_normalize_seq: RTL and testbench
===========================================

Name: fip_vector_normalize_seq

Overview:
- Sequential, parametrised fixed-point vector normaliser: outputs v / |v| for one DIM-element signed vector with FRA_BITS fraction bits.
- Supersedes the combinational normaliser. Adds a real square root, full-precision squares, iterative division, zero-vector handling, a valid/ready handshake and a stall enable.
- Sits in the ray-setup path; produces unit normals and directions for the intersection stage.

Parameters:
- WIDTH, 32: element width, signed two's complement.
- FRA_BITS, 16: fraction bits of input and output elements.
- DIM, 3: number of vector elements (2..8).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_en  in  1  stall enable; 0 freezes SUMSQ/SQRT/DIV progress.
- i_valid  in  1  input vector valid.
- o_ready  out  1  block can accept an input.
- i_vector  in  DIM*WIDTH  packed elements; element k at bits [k*WIDTH +: WIDTH].
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_vector  out  DIM*WIDTH  normalised elements, same packing and format as i_vector.
- o_zero  out  1  result came from an all-zero input.

Behaviour:
- Reset (async, i_rstn=0): state IDLE; o_ready=1, o_valid=0, o_vector=0, o_zero=0; all accumulators cleared.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE -> SUMSQ -> SQRT -> DIV -> DONE -> IDLE.
- IDLE: o_ready=1. When i_valid&&o_ready, latch i_vector and go to SUMSQ. o_ready=0 in every other state.
- SUMSQ: one element per enabled cycle (DIM cycles). Accumulate the exact product x*x into an unsigned accumulator of 2*WIDTH+clog2(DIM) bits. No truncation; the sum is in Q(2*FRA_BITS).
- SQRT: restoring bit-serial integer square root, one result bit per enabled cycle.
  - S = ceil((2*WIDTH+clog2(DIM))/2) cycles.
  - Result norm is unsigned, WIDTH+1 bits, Q(FRA_BITS), floor of the true root.
- After SQRT:
  - norm==0: set o_zero=1, o_vector=0, go to DONE.
  - otherwise: go to DIV.
- DIV: elements in order 0..DIM-1, WIDTH+FRA_BITS enabled cycles each, restoring radix-2.
  - Quotient = (|x| << FRA_BITS) / norm, truncated toward zero.
  - The input sign is reapplied afterwards.
  - |result| <= 1.0, so no saturation is needed.
  - The most-negative input is handled via a WIDTH-bit unsigned magnitude.
- Latency, i_en held 1: o_valid rises L cycles after the accepting edge.
  - L = DIM + S + DIM*(WIDTH+FRA_BITS) + 1; defaults give 181.
  - Zero vector: L = DIM + S + 1; defaults give 37.
- i_en=0: counters, accumulators and state all hold. IDLE acceptance and DONE release are unaffected by i_en.
- DONE: o_valid=1; o_vector and o_zero stable.
  - On o_valid&&i_ready: go to IDLE; o_valid=0 and o_ready=1 the next cycle.
  - o_zero clears on the next accept.
- No input is accepted in the cycle the result is released. Throughput is one vector per L+2 cycles.
- i_vector changes while busy are ignored.

Optional Feature:
- Macro FIP_NORM_ROUND_EN.
- Defined: each DIV step applies round-half-up to the magnitude (+1 if 2*remainder >= norm) before sign reapplication, clamped at 1.0 (1<<FRA_BITS). Latency is unchanged.
- Undefined: pure truncation toward zero, as above.

Test Plan:
- Input (3.0, 4.0, 0) = (0x00030000, 0x00040000, 0), i_en=1:
  - o_valid exactly 181 cycles after accept.
  - Output (0x00009999, 0x0000CCCC, 0), o_zero=0.
  - With FIP_NORM_ROUND_EN: (0x0000999A, 0x0000CCCD, 0).
- Input (0, 0, 0) -> o_valid after 37 cycles; o_vector=0, o_zero=1.
- Input (-1.0, 0, 0) = (0xFFFF0000, 0, 0) -> output (0xFFFF0000, 0, 0), same with rounding.
- Input (0x7FFFFFFF ×3) -> each output 0x000093CD (37837); the norm path must not overflow.
- Backpressure and stall:
  - Hold i_ready=0 for 10 cycles after o_valid: outputs stable, o_ready=0, a new i_valid is ignored.
  - Toggle i_en low for 5 cycles during SQRT: o_valid arrives 5 cycles later with a correct result.
- Reset mid-operation:
  - Pulse i_rstn low during DIV: o_valid=0, o_ready=1, o_vector=0 immediately.
  - The next vector (3.0, 4.0, 0) gives the scenario-1 result with 181-cycle latency.

Source files
------------

// File: rtl/fip_vector_normalize_seq.sv
// Sequential fixed-point normaliser: v/|v| via exact sum of squares, bit-serial sqrt, radix-2 divide.
// Latency DIM+S+DIM*(WIDTH+FRA_BITS)+1 (zero vector: DIM+S+1); result held until i_ready. FIP_NORM_ROUND_EN selects round-half-up.
module fip_vector_normalize_seq #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter int DIM      = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DIM*WIDTH-1:0] i_vector,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DIM*WIDTH-1:0] o_vector,
  output logic                 o_zero
);

  localparam int ACC_W = 2*WIDTH + $clog2(DIM);
  localparam int S     = (ACC_W + 1) / 2;
  localparam int SQ_W  = 2*S;
  localparam int RW    = S + 1;
  localparam int DVD_W = WIDTH + FRA_BITS;
  localparam int CNT_W = $clog2(((S > DVD_W) ? S : DVD_W) + 1);
  localparam int EL_W  = $clog2(DIM);

  localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(S);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DVD_W - 1);
  localparam logic [EL_W-1:0]  EL_LAST   = EL_W'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUMSQ = 3'd1,
    SQRT  = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DIM*WIDTH-1:0]   vec_q,   vec_d;
  logic [SQ_W-1:0]        acc_q,   acc_d;
  logic [RW-1:0]          rem_q,   rem_d;
  logic [S-1:0]           root_q,  root_d;
  logic [EL_W-1:0]        elem_q,  elem_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [DVD_W-1:0]       dvd_q,   dvd_d;
  logic [DVD_W-1:0]       quo_q,   quo_d;
  logic [S-1:0]           drem_q,  drem_d;
  logic [DIM*WIDTH-1:0]   res_q,   res_d;
  logic                   zero_q,  zero_d;

  // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  logic [WIDTH-1:0]   cur_el, cur_mag, ld_mag;
  logic [EL_W-1:0]    ld_idx;
  logic [2*WIDTH-1:0] sq;
  logic [RW+1:0]      sq_rem_sh, sq_trial, sq_rem_sub;
  logic               sq_ge;
  logic [S:0]         dv_sh, dv_sub, dv_rem;
  logic               dv_ge;
  logic [DVD_W-1:0]   quo_n;
  logic [WIDTH-1:0]   q_mag, q_rnd, q_out;
`ifdef FIP_NORM_ROUND_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRA_BITS;
  logic               rnd_up;
`endif

  always_comb begin
    cur_el  = vec_q[int'(elem_q)*WIDTH +: WIDTH];
    cur_mag = mag_of(cur_el);
    sq      = (2*WIDTH)'(cur_mag) * (2*WIDTH)'(cur_mag);

    ld_idx = (state_q == DIV) ? elem_q + EL_W'(1) : '0;
    if (int'(ld_idx) >= DIM) ld_idx = '0;
    ld_mag = mag_of(vec_q[int'(ld_idx)*WIDTH +: WIDTH]);

    // Restoring sqrt: two radicand bits enter per step from the top of the accumulator.
    sq_rem_sh  = {rem_q, acc_q[SQ_W-1 -: 2]};
    sq_trial   = {1'b0, root_q, 2'b01};
    sq_ge      = (sq_rem_sh >= sq_trial);
    sq_rem_sub = sq_rem_sh - sq_trial;

    dv_sh  = {drem_q, dvd_q[DVD_W-1]};
    dv_ge  = (dv_sh >= {1'b0, root_q});
    dv_sub = dv_sh - {1'b0, root_q};
    dv_rem = dv_ge ? dv_sub : dv_sh;
    quo_n  = DVD_W'({quo_q, dv_ge});
    q_mag  = WIDTH'(quo_n);
`ifdef FIP_NORM_ROUND_EN
    rnd_up = ({dv_rem, 1'b0} >= {2'b00, root_q});
    q_rnd  = q_mag + {{(WIDTH-1){1'b0}}, rnd_up};
    if (q_rnd > ONE) q_rnd = ONE;
`else
    q_rnd  = q_mag;
`endif
    q_out = cur_el[WIDTH-1] ? (~q_rnd + 1'b1) : q_rnd;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    root_d  = root_q;
    elem_d  = elem_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    drem_d  = drem_q;
    res_d   = res_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          vec_d   = i_vector;
          acc_d   = '0;
          elem_d  = '0;
          res_d   = '0;
          zero_d  = 1'b0;
          state_d = SUMSQ;
        end
      end

      SUMSQ: begin
        if (i_en) begin
          acc_d = acc_q + SQ_W'(sq);
          if (elem_q == EL_LAST) begin
            cnt_d   = '0;
            rem_d   = '0;
            root_d  = '0;
            state_d = SQRT;
          end else begin
            elem_d = elem_q + EL_W'(1);
          end
        end
      end

      SQRT: begin
        if (i_en) begin
          // One extra cycle after the last root bit decides between divide and zero result.
          if (cnt_q == SQRT_LAST) begin
            if (root_q == '0) begin
              zero_d  = 1'b1;
              state_d = DONE;
            end else begin
              elem_d  = '0;
              cnt_d   = '0;
              dvd_d   = {ld_mag, {FRA_BITS{1'b0}}};
              quo_d   = '0;
              drem_d  = '0;
              state_d = DIV;
            end
          end else begin
            acc_d  = acc_q << 2;
            rem_d  = RW'(sq_ge ? sq_rem_sub : sq_rem_sh);
            root_d = {root_q[S-2:0], sq_ge};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end

      DIV: begin
        if (i_en) begin
          dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
          drem_d = S'(dv_rem);
          quo_d  = quo_n;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == DIV_LAST) begin
            res_d[int'(elem_q)*WIDTH +: WIDTH] = q_out;
            if (elem_q == EL_LAST) begin
              state_d = DONE;
            end else begin
              elem_d = elem_q + EL_W'(1);
              cnt_d  = '0;
              dvd_d  = {ld_mag, {FRA_BITS{1'b0}}};
              quo_d  = '0;
              drem_d = '0;
            end
          end
        end
      end

      DONE: begin
        if (i_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      vec_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      elem_q  <= '0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      drem_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      elem_q  <= elem_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      drem_q  <= drem_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_vector = res_q;
  assign o_zero   = zero_q;

endmodule

// File: tb/tb_fip_vector_normalize_seq.sv
// Directed and randomized bench for fip_vector_normalize_seq against an arithmetic reference.
module tb_fip_vector_normalize_seq;

  localparam int W = 32;
  localparam int F = 16;
  localparam int D = 3;

  logic           i_clk = 1'b0;
  logic           i_rstn, i_en, i_valid, i_ready;
  logic [D*W-1:0] i_vector;
  logic           o_ready, o_valid, o_zero;
  logic [D*W-1:0] o_vector;

  int total  = 0;
  int passed = 0;

  fip_vector_normalize_seq #(.WIDTH(W), .FRA_BITS(F), .DIM(D)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_en     (i_en),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_vector (i_vector),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_vector (o_vector),
    .o_zero   (o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Reference: exact integer sum of squares, floor sqrt by binary search, long division.
  function automatic logic [D*W-1:0] model(input logic [D*W-1:0] v, output logic zero);
    bit [127:0] sum, mg, lo, hi, mid, q, r;
    longint xs;
    logic [W-1:0] e;
    logic [D*W-1:0] res;
    sum = 0;
    for (int k = 0; k < D; k++) begin
      xs  = longint'(signed'(v[k*W +: W]));
      mg  = (xs < 0) ? 128'(-xs) : 128'(xs);
      sum = sum + mg * mg;
    end
    lo = 0;
    hi = 128'h1 << 40;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= sum) lo = mid;
      else hi = mid - 1;
    end
    zero = (lo == 0);
    res  = '0;
    if (!zero) begin
      for (int k = 0; k < D; k++) begin
        xs = longint'(signed'(v[k*W +: W]));
        mg = (xs < 0) ? 128'(-xs) : 128'(xs);
        q  = (mg << F) / lo;
        r  = (mg << F) % lo;
`ifdef FIP_NORM_ROUND_EN
        if (2 * r >= lo) q = q + 1;
        if (q > (128'h1 << F)) q = 128'h1 << F;
`endif
        e = W'(q);
        if (xs < 0) e = -e;
        res[k*W +: W] = e;
      end
    end
    return res;
  endfunction

  task automatic accept(input logic [D*W-1:0] v);
    int n = 0;
    while (!o_ready && n < 1000) begin
      @(posedge i_clk); #1; n++;
    end
    chk("accept_ready", o_ready, 1);
    i_vector = v;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < D; k++) i_vector[k*W +: W] = $urandom;
  endtask

  task automatic wait_valid(input int budget, input bit rnd_en, output int cyc);
    cyc = 0;
    while (!o_valid && cyc < budget) begin
      if (rnd_en) i_en = ($urandom_range(0, 3) != 0);
      @(posedge i_clk); #1; cyc++;
    end
    i_en = 1'b1;
    chk("valid_within_budget", o_valid, 1);
  endtask

  task automatic check_model(input string tag, input logic [D*W-1:0] v);
    logic [D*W-1:0] ev;
    logic ez;
    ev = model(v, ez);
    chk({tag, "_vec"}, o_vector, ev);
    chk({tag, "_zero"}, o_zero, ez);
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("release_valid_low", o_valid, 0);
    chk("release_ready_high", o_ready, 1);
  endtask

  logic [D*W-1:0] v34, exp34, v, ev;
  logic ez;
  int cyc;

  initial begin
    v34 = {32'h0, 32'h0004_0000, 32'h0003_0000};
`ifdef FIP_NORM_ROUND_EN
    exp34 = {32'h0, 32'h0000_CCCD, 32'h0000_999A};
`else
    exp34 = {32'h0, 32'h0000_CCCC, 32'h0000_9999};
`endif
    i_rstn = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_vector = '0;
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_vector", o_vector, 0);
    chk("rst_zero", o_zero, 0);
    @(posedge i_clk); #3; i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // (3,4,0)
    accept(v34);
    wait_valid(400, 0, cyc);
    chk("lat_345", cyc, 181);
    chk("vec_345", o_vector, exp34);
    chk("zero_345", o_zero, 0);
    check_model("model_345", v34);
    release_result();

    // zero vector; o_zero persists until the next accept
    accept('0);
    wait_valid(400, 0, cyc);
    chk("lat_zero", cyc, 37);
    chk("vec_zero", o_vector, 0);
    chk("zero_flag", o_zero, 1);
    release_result();
    chk("zero_flag_held", o_zero, 1);

    // -1.0
    v = {32'h0, 32'h0, 32'hFFFF_0000};
    accept(v);
    chk("zero_cleared_on_accept", o_zero, 0);
    wait_valid(400, 0, cyc);
    chk("lat_neg1", cyc, 181);
    chk("vec_neg1", o_vector, v);
    release_result();

    // largest positive elements
    accept({3{32'h7FFF_FFFF}});
    wait_valid(400, 0, cyc);
    chk("vec_max", o_vector, {3{32'h0000_93CD}});
    chk("zero_max", o_zero, 0);
    release_result();

    // most-negative element
    accept({32'h0, 32'h0, 32'h8000_0000});
    wait_valid(400, 0, cyc);
    chk("vec_minneg", o_vector, {32'h0, 32'h0, 32'hFFFF_0000});
    release_result();

    // backpressure: result held for 10 cycles, new input ignored
    v = {32'hFFFD_8000, 32'h0001_2000, 32'h0000_4000};
    ev = model(v, ez);
    i_ready = 1'b0;
    accept(v);
    wait_valid(400, 0, cyc);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_vector = v34;
      @(posedge i_clk); #1;
      chk("bp_valid", o_valid, 1);
      chk("bp_vec", o_vector, ev);
      chk("bp_ready", o_ready, 0);
    end
    i_valid = 1'b0;
    release_result();
    @(posedge i_clk); #1;
    chk("bp_not_accepted", o_ready, 1);

    // stall 5 cycles inside SQRT
    accept(v34);
    repeat (10) begin @(posedge i_clk); #1; end
    i_en = 1'b0;
    repeat (5) begin @(posedge i_clk); #1; end
    i_en = 1'b1;
    wait_valid(400, 0, cyc);
    chk("lat_stall", cyc + 15, 186);
    chk("vec_stall", o_vector, exp34);
    release_result();

    // reset during DIV
    accept(v34);
    repeat (100) begin @(posedge i_clk); #1; end
    i_rstn = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_vector", o_vector, 0);
    #2; i_rstn = 1'b1;
    @(posedge i_clk); #1;
    accept(v34);
    wait_valid(400, 0, cyc);
    chk("lat_after_rst", cyc, 181);
    chk("vec_after_rst", o_vector, exp34);
    release_result();

    // randomized vectors, odd iterations with random stalls
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < D; k++) begin
        int e;
        e = int'($urandom);
        e = e >>> $urandom_range(0, 20);
        if ($urandom_range(0, 5) == 0) e = 0;
        v[k*W +: W] = e;
      end
      accept(v);
      wait_valid(3000, it[0], cyc);
      if (!it[0]) chk("lat_rand", cyc, model_latency(v));
      check_model("rand", v);
      release_result();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  function automatic int model_latency(input logic [D*W-1:0] vv);
    logic z;
    logic [D*W-1:0] dummy;
    dummy = model(vv, z);
    return z ? (D + 33 + 1) : (D + 33 + D*(W+F) + 1);
  endfunction

endmodule
